// File: rtl/operand_serializer_if.sv
// Operand load handshake and serial output bundle
// for the bit-serial adder feeder.
interface operand_serializer_if #(
  parameter int reglength = 3
);
  logic [reglength-1:0] a;
  logic [reglength-1:0] b;
  logic                 load_valid;
  logic                 load_ready;
  logic                 r1;
  logic                 r2;
  logic                 frame;
  logic                 first;
  logic                 done;

  modport master (
    output a, b, load_valid,
    input  load_ready, r1, r2, frame, first, done
  );

  modport slave (
    input  a, b, load_valid,
    output load_ready, r1, r2, frame, first, done
  );
endinterface

// File: rtl/operand_serializer.sv
// Shifts two operands out LSB-first followed by
// zero flush slots that drain the adder carry.
module operand_serializer #(
  parameter int reglength = 3,
  parameter int flush_len = 1
) (
  input logic                 clk,
  input logic                 rst,
  operand_serializer_if.slave sif
);
  localparam int TOT = reglength + flush_len;
  localparam int CW  = $clog2(TOT) + 1;
  localparam logic [CW-1:0] LAST_D = CW'(reglength - 1);
  localparam logic [CW-1:0] LAST_F = CW'(TOT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH
  } state_t;

  state_t               state;
  logic [reglength-1:0] sa;
  logic [reglength-1:0] sb;
  logic [reglength-1:0] sa_sh;
  logic [reglength-1:0] sb_sh;
  logic [CW-1:0]        cnt;

  // next bit of each operand, zero-filled from the top
  assign sa_sh = sa >> 1;
  assign sb_sh = sb >> 1;

  // frame sequencer; cnt holds the slot index on the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sa             <= '0;
      sb             <= '0;
      cnt            <= '0;
      sif.r1         <= 1'b0;
      sif.r2         <= 1'b0;
      sif.frame      <= 1'b0;
      sif.first      <= 1'b0;
      sif.done       <= 1'b0;
      sif.load_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          sif.done <= 1'b0;
          if (sif.load_valid) begin
            state          <= SHIFT;
            sa             <= sif.a;
            sb             <= sif.b;
            cnt            <= '0;
            sif.r1         <= sif.a[0];
            sif.r2         <= sif.b[0];
            sif.frame      <= 1'b1;
            sif.first      <= 1'b1;
            sif.load_ready <= 1'b0;
          end
        end
        SHIFT: begin
          sif.first <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_D) begin
            state  <= FLUSH;
            sif.r1 <= 1'b0;
            sif.r2 <= 1'b0;
          end else begin
            sa     <= sa_sh;
            sb     <= sb_sh;
            sif.r1 <= sa_sh[0];
            sif.r2 <= sb_sh[0];
          end
        end
        FLUSH: begin
          if (cnt == LAST_F) begin
            state          <= IDLE;
            sif.frame      <= 1'b0;
            sif.done       <= 1'b1;
            sif.load_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
